bus_requester: RTL

BUS_REQUESTER -- requirements
Module: bus_requester

---
 rtl/bus_requester.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/bus_requester.sv
// Bus requester: buffers host words in a FIFO and issues whole bursts onto a
// shared bus through a request/grant handshake with a round-robin arbiter.
module bus_requester #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    output logic              req,
    input  logic              grant,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_last,
    output logic              busy,
    output logic              timeout,
    output logic              err_overflow,
    output logic              err_len
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

    state_t            state, state_nx;
    logic [DATA_W:0]   mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     burst_cnt;
    logic [WW-1:0]     wait_cnt, wait_cnt_nx;
    logic [DATA_W:0]   head;
    logic              full, empty;
    logic              push, pop, flush;
    logic              push_last, pop_last;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head      = mem[rd_ptr];
    assign wr_ready  = !full;
    assign pop       = bus_valid;
    // A pop frees the slot, so a full FIFO still takes a word on a beat cycle.
    assign push      = wr_valid && (!full || pop);
    assign push_last = push && wr_last;
    assign pop_last  = pop && head[DATA_W];
    assign bus_data  = empty ? '0 : head[DATA_W-1:0];
    assign bus_last  = bus_valid && head[DATA_W];
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        req         = 1'b0;
        bus_valid   = 1'b0;
        timeout     = 1'b0;
        flush       = 1'b0;
        case (state)
            IDLE: begin
                if (burst_cnt != '0) begin
                    state_nx    = REQ;
                    wait_cnt_nx = '0;
                end else if (full) begin
                    // Full with no burst end can never drain: discard it.
                    flush = 1'b1;
                end
            end
            REQ: begin
                req = 1'b1;
                if (grant) begin
                    state_nx    = XFER;
                    wait_cnt_nx = '0;
                end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                    timeout     = 1'b1;
                    wait_cnt_nx = '0;
                end else begin
                    wait_cnt_nx = wait_cnt + WW'(1);
                end
            end
            XFER: begin
                req       = 1'b1;
                bus_valid = grant && !empty;
                if (bus_valid && head[DATA_W]) begin
                    state_nx = GAP;
                end
            end
            GAP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            burst_cnt    <= '0;
            err_overflow <= 1'b0;
            err_len      <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
            if (push_last && !pop_last) begin
                burst_cnt <= burst_cnt + CW'(1);
            end else if (pop_last && !push_last) begin
                burst_cnt <= burst_cnt - CW'(1);
            end
            if (wr_valid && full && !pop) begin
                err_overflow <= 1'b1;
            end
            if (flush) begin
                err_len <= 1'b1;
            end
        end
    end

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {wr_last, wr_data};
        end
    end

endmodule
